// File: rtl/pixels_pkg.sv
// Shared types and width helpers for the pixel window path.
package pixels_pkg;

    localparam int unsigned PIX_USER_WIDTH = 8;

    typedef enum logic {
        CORE_EMPTY = 1'b0,
        CORE_SHIFT = 1'b1
    } core_state_e;

    typedef struct packed {
        logic                      first;
        logic                      last;
        logic [PIX_USER_WIDTH-1:0] user;
    } pix_side_t;

    function automatic int unsigned bits_kh(input int unsigned kh_max);
        return 32'($clog2(kh_max));
    endfunction

    function automatic int unsigned bits_sh(input int unsigned sh_max);
        return 32'($clog2(sh_max + 1));
    endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Full-throughput skid slice: data passes straight through while the spare
// entry is empty, and the spare entry absorbs one beat on a stall.
module axis_skid_reg #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
);

    logic                  sk_valid_q, sk_valid_d;
    logic [DATA_WIDTH-1:0] sk_data_q,  sk_data_d;

    always_comb begin
        sk_valid_d = sk_valid_q;
        sk_data_d  = sk_data_q;
        if (sk_valid_q) begin
            if (m_ready) begin
                sk_valid_d = 1'b0;
            end
        end else if (s_valid && !m_ready) begin
            sk_valid_d = 1'b1;
            sk_data_d  = s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sk_valid_q <= 1'b0;
            sk_data_q  <= '0;
        end else begin
            sk_valid_q <= sk_valid_d;
            sk_data_q  <= sk_data_d;
        end
    end

    // Ready is a pure flop output, so upstream never sees m_ready combinationally.
    assign s_ready = ~sk_valid_q;
    assign m_valid = s_valid | sk_valid_q;
    assign m_data  = sk_valid_q ? sk_data_q : s_data;

endmodule

// File: rtl/axis_pixels_window.sv
// Sliding pixel window: holds one input row and emits SHIFT+1 sliced beats,
// sliding by STRIDE words per beat with FILL entering at the top.
module axis_pixels_window
    import pixels_pkg::*;
#(
    parameter int unsigned           COPIES        = 2,
    parameter int unsigned           UNITS         = 4,
    parameter int unsigned           WORD_WIDTH    = 8,
    parameter int unsigned           IM_SHIFT_REGS = 16,
    parameter int unsigned           KH_MAX        = 11,
    parameter int unsigned           SH_MAX        = 4,
    parameter int unsigned           USER_WIDTH    = 8,
    parameter logic [WORD_WIDTH-1:0] FILL          = '0
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [IM_SHIFT_REGS*WORD_WIDTH-1:0] s_data,
    input  logic [bits_kh(KH_MAX)-1:0]          s_shift,
    input  logic [bits_sh(SH_MAX)-1:0]          s_stride,
    input  logic                                s_slice,
    input  logic                                s_ones,
    input  logic [USER_WIDTH-1:0]               s_user,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [COPIES*UNITS*WORD_WIDTH-1:0]  m_data,
    output logic [USER_WIDTH-1:0]               m_user,
    output logic                                m_first,
    output logic                                m_last
);

    localparam int unsigned BITS_KH = bits_kh(KH_MAX);
    localparam int unsigned BITS_SH = bits_sh(SH_MAX);
    localparam int unsigned ROW_W   = IM_SHIFT_REGS * WORD_WIDTH;
    localparam int unsigned OUT_W   = COPIES * UNITS * WORD_WIDTH;
    localparam int unsigned PAY_W   = OUT_W + USER_WIDTH + 2;

    if (IM_SHIFT_REGS < COPIES * UNITS) begin : g_size_check
        $error("axis_pixels_window: IM_SHIFT_REGS must be >= COPIES*UNITS");
    end

    core_state_e            state_q,  state_d;
    logic [ROW_W-1:0]       row_q,    row_d;
    logic [BITS_KH-1:0]     count_q,  count_d;
    logic                   beat0_q,  beat0_d;
    logic [USER_WIDTH-1:0]  user_q,   user_d;
    logic [BITS_SH-1:0]     stride_q, stride_d;
    logic                   mode_q,   mode_d;

    logic                   core_valid;
    logic                   last_c;
    logic                   adv;
    logic                   skid_ready;
    logic [ROW_W-1:0]       shifted_c;
    logic [OUT_W-1:0]       win_c;
    logic [PAY_W-1:0]       core_pay;
    logic [PAY_W-1:0]       out_pay;

    assign core_valid = (state_q == CORE_SHIFT);
    assign last_c     = (count_q == '0);
    assign adv        = core_valid & skid_ready;
    assign s_ready    = ~core_valid | (adv & last_c);

    // Row slid down by the latched stride; words shifted past the top become FILL.
    always_comb begin
        int unsigned src;
        src       = 0;
        shifted_c = '0;
        for (int unsigned i = 0; i < IM_SHIFT_REGS; i++) begin
            src = i + 32'(stride_q);
            if (src < IM_SHIFT_REGS) begin
                shifted_c[i*WORD_WIDTH +: WORD_WIDTH] = row_q[src*WORD_WIDTH +: WORD_WIDTH];
            end else begin
                shifted_c[i*WORD_WIDTH +: WORD_WIDTH] = FILL;
            end
        end
    end

    // Per-copy slices in pooling mode, otherwise every copy sees words [0, UNITS).
    always_comb begin
        int unsigned src;
        src   = 0;
        win_c = '0;
        for (int unsigned c = 0; c < COPIES; c++) begin
            for (int unsigned u = 0; u < UNITS; u++) begin
                src = (mode_q ? c * UNITS : 32'd0) + u;
                win_c[(c*UNITS+u)*WORD_WIDTH +: WORD_WIDTH] = row_q[src*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    // A new row takes priority over retiring the last beat of the previous one.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        count_d  = count_q;
        beat0_d  = beat0_q;
        user_d   = user_q;
        stride_d = stride_q;
        mode_d   = mode_q;
        if (s_valid && s_ready) begin
            state_d = CORE_SHIFT;
            row_d   = s_data;
            count_d = (s_shift > BITS_KH'(KH_MAX - 1)) ? BITS_KH'(KH_MAX - 1) : s_shift;
            beat0_d = 1'b1;
            user_d  = s_user;
            mode_d  = s_slice & ~s_ones;
            if (s_stride == '0) begin
                stride_d = BITS_SH'(1);
            end else if (s_stride > BITS_SH'(SH_MAX)) begin
                stride_d = BITS_SH'(SH_MAX);
            end else begin
                stride_d = s_stride;
            end
        end else if (adv) begin
            if (last_c) begin
                state_d = CORE_EMPTY;
            end else begin
                row_d   = shifted_c;
                count_d = count_q - BITS_KH'(1);
                beat0_d = 1'b0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= CORE_EMPTY;
            row_q    <= '0;
            count_q  <= '0;
            beat0_q  <= 1'b0;
            user_q   <= '0;
            stride_q <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            count_q  <= count_d;
            beat0_q  <= beat0_d;
            user_q   <= user_d;
            stride_q <= stride_d;
            mode_q   <= mode_d;
        end
    end

    assign core_pay = {beat0_q & core_valid, last_c & core_valid, user_q, win_c};

    axis_skid_reg #(
        .DATA_WIDTH(PAY_W)
    ) u_skid (
        .clk     (aclk),
        .rst_n   (aresetn),
        .s_valid (core_valid),
        .s_ready (skid_ready),
        .s_data  (core_pay),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (out_pay)
    );

    assign {m_first, m_last, m_user, m_data} = out_pay;

endmodule

// File: tb/tb_axis_pixels_window.sv
// Directed bench for axis_pixels_window: table of row groups plus stall and reset sequences.
module tb_axis_pixels_window;

    localparam int NW    = 16;
    localparam int UNITS = 4;
    localparam int COPIES = 2;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic [3:0]   s_shift;
    logic [2:0]   s_stride;
    logic         s_slice;
    logic         s_ones;
    logic [7:0]   s_user;
    logic         m_valid;
    logic         m_ready;
    logic [63:0]  m_data;
    logic [7:0]   m_user;
    logic         m_first;
    logic         m_last;

    axis_pixels_window dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_shift  (s_shift),
        .s_stride (s_stride),
        .s_slice  (s_slice),
        .s_ones   (s_ones),
        .s_user   (s_user),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_user   (m_user),
        .m_first  (m_first),
        .m_last   (m_last)
    );

    always #5 aclk = ~aclk;

    // eff/mode/nbeats are the hand-derived effective stride, slice mode and beat count.
    typedef struct {
        logic [3:0] shift;
        logic [2:0] stride;
        logic       slice;
        logic       ones;
        logic [7:0] user;
        logic [7:0] off;
        int         eff;
        logic       mode;
        int         nbeats;
    } grp_t;

    typedef struct packed {
        logic        first;
        logic        last;
        logic [7:0]  user;
        logic [63:0] data;
    } beat_t;

    int    total = 0;
    int    bad   = 0;
    int    nbeat = 0;
    beat_t exp_q[$];
    grp_t  grps[10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk_beat(input grp_t g, input int k);
        beat_t b;
        int p;
        b.first = (k == 0);
        b.last  = (k == g.nbeats - 1);
        b.user  = g.user;
        b.data  = '0;
        for (int c = 0; c < COPIES; c++) begin
            for (int u = 0; u < UNITS; u++) begin
                p = k * g.eff + (g.mode ? c * UNITS : 0) + u;
                b.data[(c*UNITS+u)*8 +: 8] = (p < NW) ? 8'(g.off + 8'(p)) : 8'h00;
            end
        end
        return b;
    endfunction

    task automatic queue_group(input grp_t g);
        for (int k = 0; k < g.nbeats; k++) exp_q.push_back(mk_beat(g, k));
    endtask

    // Presents a row from a falling edge and returns on the rising edge that accepts it.
    task automatic send_row(input grp_t g);
        int guard;
        @(negedge aclk);
        for (int i = 0; i < NW; i++) s_data[i*8 +: 8] = 8'(g.off + 8'(i));
        s_shift  = g.shift;
        s_stride = g.stride;
        s_slice  = g.slice;
        s_ones   = g.ones;
        s_user   = g.user;
        s_valid  = 1'b1;
        guard    = 0;
        while (!s_ready && guard < 200) begin
            @(negedge aclk);
            guard++;
        end
        if (!s_ready) begin
            total++;
            bad++;
            $display("FAIL send_row_timeout: actual=s_ready low required=s_ready high");
        end
        @(posedge aclk);
    endtask

    task automatic consume(input bit rnd, input int budget, output int first_cyc, output int last_cyc);
        beat_t held, cur, e;
        bit    holding;
        int    cyc;
        holding   = 1'b0;
        cyc       = 0;
        first_cyc = -1;
        last_cyc  = -1;
        while (exp_q.size() > 0 && cyc < budget) begin
            @(negedge aclk);
            cyc++;
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cur = {m_first, m_last, m_user, m_data};
            if (holding) begin
                check("stall_hold", {m_valid, cur}, {1'b1, held});
                holding = 1'b0;
            end
            if (m_valid) begin
                if (m_ready) begin
                    e = exp_q.pop_front();
                    check($sformatf("beat%0d", nbeat), cur, e);
                    nbeat++;
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                end else begin
                    holding = 1'b1;
                    held    = cur;
                end
            end
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL consume_timeout: actual=%0d beats left required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc, lc, sum_beats;
        grp_t g;

        grps[0] = '{4'd2,  3'd1, 1'b1, 1'b0, 8'h11, 8'h00, 1, 1'b1, 3};
        grps[1] = '{4'd2,  3'd3, 1'b0, 1'b0, 8'h22, 8'h10, 3, 1'b0, 3};
        grps[2] = '{4'd2,  3'd3, 1'b1, 1'b1, 8'h33, 8'h20, 3, 1'b0, 3};
        grps[3] = '{4'd5,  3'd4, 1'b1, 1'b0, 8'h44, 8'h30, 4, 1'b1, 6};
        grps[4] = '{4'd2,  3'd0, 1'b1, 1'b0, 8'h55, 8'h40, 1, 1'b1, 3};
        grps[5] = '{4'd1,  3'd7, 1'b1, 1'b0, 8'h66, 8'h50, 4, 1'b1, 2};
        grps[6] = '{4'd0,  3'd1, 1'b1, 1'b0, 8'h77, 8'h60, 1, 1'b1, 1};
        grps[7] = '{4'd0,  3'd1, 1'b1, 1'b0, 8'h88, 8'h70, 1, 1'b1, 1};
        grps[8] = '{4'd0,  3'd1, 1'b1, 1'b0, 8'h99, 8'h80, 1, 1'b1, 1};
        grps[9] = '{4'd15, 3'd1, 1'b0, 1'b0, 8'hAA, 8'h90, 1, 1'b0, 11};

        aresetn  = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_shift  = '0;
        s_stride = '0;
        s_slice  = 1'b0;
        s_ones   = 1'b0;
        s_user   = '0;
        m_ready  = 1'b0;

        #12;
        check("rst_s_ready", s_ready, 1'b1);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data",  m_data,  64'h0);
        check("rst_m_user",  m_user,  8'h0);
        check("rst_m_first", m_first, 1'b0);
        check("rst_m_last",  m_last,  1'b0);
        @(negedge aclk);
        aresetn = 1'b1;
        m_ready = 1'b1;

        // Back-to-back groups with m_ready high: every beat checked, no gaps allowed.
        sum_beats = 0;
        foreach (grps[i]) begin
            queue_group(grps[i]);
            sum_beats += grps[i].nbeats;
        end
        fork
            begin
                foreach (grps[i]) send_row(grps[i]);
                @(negedge aclk);
                s_valid = 1'b0;
            end
            consume(1'b0, 500, fc, lc);
        join
        check("no_bubbles", 128'(lc - fc + 1), 128'(sum_beats));

        // Random back-pressure over an 11-beat group.
        g = '{4'd10, 3'd1, 1'b1, 1'b0, 8'hB5, 8'hB0, 1, 1'b1, 11};
        queue_group(g);
        fork
            begin
                send_row(g);
                @(negedge aclk);
                s_valid = 1'b0;
            end
            consume(1'b1, 400, fc, lc);
        join
        m_ready = 1'b1;
        repeat (4) begin
            @(negedge aclk);
            check("no_extra_beat", m_valid, 1'b0);
        end

        // Reset in the middle of a 5-beat group.
        g = '{4'd4, 3'd1, 1'b1, 1'b0, 8'hC3, 8'hC0, 1, 1'b1, 5};
        send_row(g);
        @(negedge aclk);
        s_valid = 1'b0;
        check("lat_beat0", {m_valid, m_first, m_last, m_user, m_data}, {1'b1, mk_beat(g, 0)});
        @(negedge aclk);
        check("mid_beat1", {m_valid, m_first, m_last, m_user, m_data}, {1'b1, mk_beat(g, 1)});
        @(negedge aclk);
        check("mid_beat2", {m_valid, m_first, m_last, m_user, m_data}, {1'b1, mk_beat(g, 2)});
        aresetn = 1'b0;
        #1;
        check("async_rst_m_valid", m_valid, 1'b0);
        check("async_rst_s_ready", s_ready, 1'b1);
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            check("post_rst_idle", m_valid, 1'b0);
        end
        g = '{4'd1, 3'd2, 1'b1, 1'b0, 8'hD7, 8'hD0, 2, 1'b1, 2};
        queue_group(g);
        fork
            begin
                send_row(g);
                @(negedge aclk);
                s_valid = 1'b0;
            end
            consume(1'b0, 50, fc, lc);
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
